k_counter: RTL and testbench
============================

K_COUNTER -- requirements
Module: k_counter

Interface
REQ-001 The block SHALL have parameter KBITS, default 4, counter width; modulus K = 2^KBITS, legal range 2..16.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port enable  input  1  count enable; low freezes both counters.
REQ-005 The block SHALL have port dnUp  input  1  phase-detector error; 0 = count up, 1 = count down.
REQ-006 The block SHALL have port carry  output  1  one-cycle increment pulse to the IDCounter incIn.
REQ-007 The block SHALL have port borrow  output  1  one-cycle decrement pulse to the IDCounter decIn.
REQ-008 The block SHALL have port upCount  output  KBITS  current up-counter value.
REQ-009 The block SHALL have port dnCount  output  KBITS  current down-counter value.

Function
REQ-010 The block SHALL hold two independent modulo-K counters, upCount and dnCount; all outputs SHALL be registered.
REQ-011 With enable=1 and dnUp=0, upCount SHALL increment by 1 per clk and dnCount SHALL hold.
REQ-012 With enable=1 and dnUp=1, dnCount SHALL increment by 1 per clk and upCount SHALL hold.
REQ-013 With enable=0, both counters SHALL hold, and carry and borrow SHALL be 0.
REQ-014 When upCount wraps K-1 -> 0, carry SHALL be 1 for exactly that one cycle, asserted on the same edge that loads 0.
REQ-015 When dnCount wraps K-1 -> 0, borrow SHALL be 1 for exactly that one cycle, asserted on the same edge that loads 0.
REQ-016 carry and borrow SHALL never be 1 in the same cycle.
REQ-017 With enable=1 continuously and dnUp constant, carry or borrow SHALL pulse once every K cycles, with K-1 low cycles between pulses.
REQ-018 A dnUp change SHALL take effect on the next rising edge; no count SHALL be lost or duplicated.
REQ-019 A wrap SHALL occur only on an enabled edge; deasserting enable at count K-1 SHALL hold K-1 without a pulse.

Reset
REQ-020 While reset=1 at a rising edge, upCount and dnCount SHALL become 0, and carry and borrow SHALL become 0.
REQ-021 reset SHALL take priority over enable and dnUp.
REQ-022 reset asserted in the cycle a wrap would occur SHALL suppress that pulse.
REQ-023 The first count after reset release SHALL take the counter from 0 to 1.

Configuration
REQ-024 Macro KCNT_OPPOSITE_CLEAR_EN SHALL select random-walk filter mode.
REQ-025 With KCNT_OPPOSITE_CLEAR_EN defined, the edge that asserts carry SHALL also clear dnCount to 0, and the edge that asserts borrow SHALL also clear upCount to 0.
REQ-026 Without KCNT_OPPOSITE_CLEAR_EN defined, the two counters SHALL be fully independent, per REQ-011 to REQ-015.
REQ-027 Port list and timing SHALL be identical in both builds.

Verification (KBITS=4, K=16)
REQ-028 Reset held for 3 cycles, then enable=1, dnUp=0 for 40 cycles -> carry high on cycles 16 and 32 after release, upCount=8 at cycle 40, and borrow=0, dnCount=0 throughout.
REQ-029 enable=1, dnUp=1 for 16 cycles -> a single borrow pulse on cycle 16, and dnCount=0 afterwards.
REQ-030 Non-macro build: 10 cycles dnUp=0, then 16 cycles dnUp=1 -> borrow on the 26th cycle, upCount stays 10, and no carry occurs.
REQ-031 KCNT_OPPOSITE_CLEAR_EN build: 10 cycles dnUp=1, then 16 cycles dnUp=0 -> carry on the 26th cycle with dnCount cleared from 10 to 0 on the same edge.
REQ-032 Count to upCount=15, hold enable=0 for 5 cycles, then enable=1 -> no pulse while disabled, and carry on the first enabled edge.
REQ-033 Assert reset at upCount=15 in the cycle a wrap would occur -> carry stays 0, and upCount=0.
REQ-034 Across all scenarios, carry and borrow SHALL never be high together, and each pulse SHALL be exactly 1 cycle wide.

Source files
------------

// File: rtl/k_counter.sv
// Dual modulo-K up/down counter (K-counter) feeding an increment/decrement counter.
// Optional build macro KCNT_OPPOSITE_CLEAR_EN selects random-walk filter mode.
module k_counter #(
    parameter int unsigned KBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dnUp,
    output logic             carry,
    output logic             borrow,
    output logic [KBITS-1:0] upCount,
    output logic [KBITS-1:0] dnCount
);

    localparam logic [KBITS-1:0] CNT_MAX = {KBITS{1'b1}};
    localparam logic [KBITS-1:0] CNT_ONE = KBITS'(1);

    logic             up_step;
    logic             dn_step;
    logic             up_wrap;
    logic             dn_wrap;
    logic [KBITS-1:0] up_next;
    logic [KBITS-1:0] dn_next;

    // Only one counter advances per enabled edge, so carry and borrow are exclusive.
    always_comb begin
        up_step = enable & ~dnUp;
        dn_step = enable & dnUp;
        up_wrap = up_step & (upCount == CNT_MAX);
        dn_wrap = dn_step & (dnCount == CNT_MAX);
        up_next = upCount + CNT_ONE;
        dn_next = dnCount + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upCount <= '0;
            dnCount <= '0;
            carry   <= 1'b0;
            borrow  <= 1'b0;
        end else begin
            carry  <= up_wrap;
            borrow <= dn_wrap;
            if (up_step) begin
                upCount <= up_next;
            end
            if (dn_step) begin
                dnCount <= dn_next;
            end
`ifdef KCNT_OPPOSITE_CLEAR_EN
            // Random-walk mode: a wrap on one side discards progress on the other.
            if (up_wrap) begin
                dnCount <= '0;
            end
            if (dn_wrap) begin
                upCount <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_k_counter.sv
// Self-checking bench for k_counter (KBITS=4): scoreboard model plus directed wrap/enable/reset sequences.
// Works for both builds; KCNT_OPPOSITE_CLEAR_EN switches the model and the directed scenario.
module tb_k_counter;

    localparam int unsigned KBITS = 4;
    localparam int unsigned K     = 16;

    typedef struct {
        logic             c;
        logic             b;
        logic [KBITS-1:0] u;
        logic [KBITS-1:0] d;
    } exp_t;

    typedef struct {
        logic rst;
        logic en;
        logic dn;
        int   cycles;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             dnUp;
    logic             carry;
    logic             borrow;
    logic [KBITS-1:0] upCount;
    logic [KBITS-1:0] dnCount;

    int tests = 0;
    int fails = 0;

    exp_t sb_q[$];
    int   m_up = 0;
    int   m_dn = 0;
    logic prev_c = 1'b0;
    logic prev_b = 1'b0;

    k_counter #(.KBITS(KBITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .dnUp    (dnUp),
        .carry   (carry),
        .borrow  (borrow),
        .upCount (upCount),
        .dnCount (dnCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle, predict its result, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic d);
        exp_t x;
        exp_t got;
        @(negedge clk);
        reset  = r;
        enable = e;
        dnUp   = d;
        x.c = 1'b0;
        x.b = 1'b0;
        if (r) begin
            m_up = 0;
            m_dn = 0;
        end else if (e && !d) begin
            if (m_up == K - 1) begin
                m_up = 0;
                x.c  = 1'b1;
`ifdef KCNT_OPPOSITE_CLEAR_EN
                m_dn = 0;
`endif
            end else begin
                m_up = m_up + 1;
            end
        end else if (e && d) begin
            if (m_dn == K - 1) begin
                m_dn = 0;
                x.b  = 1'b1;
`ifdef KCNT_OPPOSITE_CLEAR_EN
                m_up = 0;
`endif
            end else begin
                m_dn = m_dn + 1;
            end
        end
        x.u = KBITS'(m_up);
        x.d = KBITS'(m_dn);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            got = sb_q.pop_front();
            chk("sb_carry",   int'(carry),   int'(got.c));
            chk("sb_borrow",  int'(borrow),  int'(got.b));
            chk("sb_upCount", int'(upCount), int'(got.u));
            chk("sb_dnCount", int'(dnCount), int'(got.d));
        end
        chk("exclusive_pulse", int'(carry & borrow), 0);
        if (prev_c) chk("carry_width",  int'(carry),  0);
        if (prev_b) chk("borrow_width", int'(borrow), 0);
        prev_c = carry;
        prev_b = borrow;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    vec_t vecs[10];

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        dnUp   = 1'b0;

        vecs[0] = '{rst: 1'b1, en: 1'b1, dn: 1'b1, cycles: 2};
        vecs[1] = '{rst: 1'b0, en: 1'b1, dn: 1'b1, cycles: 20};
        vecs[2] = '{rst: 1'b0, en: 1'b0, dn: 1'b0, cycles: 4};
        vecs[3] = '{rst: 1'b0, en: 1'b1, dn: 1'b0, cycles: 17};
        vecs[4] = '{rst: 1'b0, en: 1'b0, dn: 1'b1, cycles: 3};
        vecs[5] = '{rst: 1'b0, en: 1'b1, dn: 1'b0, cycles: 15};
        vecs[6] = '{rst: 1'b0, en: 1'b1, dn: 1'b1, cycles: 13};
        vecs[7] = '{rst: 1'b1, en: 1'b1, dn: 1'b0, cycles: 1};
        vecs[8] = '{rst: 1'b0, en: 1'b1, dn: 1'b0, cycles: 1};
        vecs[9] = '{rst: 1'b0, en: 1'b1, dn: 1'b1, cycles: 33};

        // Reset state, then up-counting for 40 cycles.
        do_reset(3);
        chk("reset_up",     int'(upCount), 0);
        chk("reset_dn",     int'(dnCount), 0);
        chk("reset_carry",  int'(carry),   0);
        chk("reset_borrow", int'(borrow),  0);
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("a_carry",  int'(carry),  (i == 16 || i == 32) ? 1 : 0);
            chk("a_borrow", int'(borrow), 0);
            chk("a_dn",     int'(dnCount), 0);
            if (i == 1)  chk("a_first_count", int'(upCount), 1);
            if (i == 40) chk("a_up_at_40",    int'(upCount), 8);
        end

        // 16 down cycles give a single borrow.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("b_borrow", int'(borrow), (i == 16) ? 1 : 0);
            chk("b_carry",  int'(carry),  0);
        end
        chk("b_dn_after", int'(dnCount), 0);

`ifdef KCNT_OPPOSITE_CLEAR_EN
        // Carry on the 26th cycle clears dnCount from 10.
        do_reset(1);
        for (int i = 1; i <= 26; i++) begin
            step(1'b0, 1'b1, (i <= 10) ? 1'b0 : 1'b1);
        end
        do_reset(1);
        for (int i = 1; i <= 26; i++) begin
            step(1'b0, 1'b1, (i <= 10) ? 1'b1 : 1'b0);
            chk("c_carry",  int'(carry),  (i == 26) ? 1 : 0);
            chk("c_borrow", int'(borrow), 0);
            if (i == 25) chk("c_dn_before", int'(dnCount), 10);
            if (i == 26) chk("c_dn_cleared", int'(dnCount), 0);
        end
`else
        // Independent counters: borrow on the 26th cycle, upCount parked at 10.
        do_reset(1);
        for (int i = 1; i <= 26; i++) begin
            step(1'b0, 1'b1, (i <= 10) ? 1'b0 : 1'b1);
            chk("c_borrow", int'(borrow), (i == 26) ? 1 : 0);
            chk("c_carry",  int'(carry),  0);
            if (i >= 10) chk("c_up_hold", int'(upCount), 10);
        end
        chk("c_dn_wrapped", int'(dnCount), 0);
`endif

        // Disable at K-1: hold without pulse, wrap on first enabled edge.
        do_reset(1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
        chk("d_up_15", int'(upCount), 15);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("d_hold_up",    int'(upCount), 15);
            chk("d_hold_carry", int'(carry),   0);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("d_wrap_carry", int'(carry),   1);
        chk("d_wrap_up",    int'(upCount), 0);

        // Reset in the wrap cycle suppresses the pulse.
        do_reset(1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("e_carry", int'(carry),   0);
        chk("e_up",    int'(upCount), 0);

        // Table-driven phases.
        for (int v = 0; v < 10; v++) begin
            for (int n = 0; n < vecs[v].cycles; n++) begin
                step(vecs[v].rst, vecs[v].en, vecs[v].dn);
            end
        end

        // Pseudo-random traffic with rare resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
